// File: rtl/pi_cmd_fifo.sv
// pi_cmd_fifo
//
// Posted-transaction queue between the Pi register-write decoder and the 68k
// bus-cycle sequencer, in the Pi GPIO clock domain. Register writes stage a
// data word and the low address half. Each ADDR_HI write commits one complete
// bus transaction into a DEPTH-entry first-word-fall-through FIFO. The head
// entry is offered to the sequencer over a valid/ready handshake, with at
// most one bus cycle in flight at a time.
//
// Optional build macro:
//   PI_CMD_FIFO_AUTOINC_EN - every accepted commit advances the staged address
//                            (by 1 for byte, by 2 for word, wrapping in 16
//                            bits) and keeps the staged-pending flag set, so
//                            repeated ADDR_HI writes stream sequential cycles.
//
// Ports:
//   PI_CLK     in   Pi-side clock, rising edge
//   PI_RST     in   synchronous active-high reset
//   wr_stb     in   one-cycle pulse, a Pi register write completed
//   wr_reg     in   register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS
//   wr_data    in   register write value
//   clr_ovf    in   one-cycle pulse, clears ovf
//   cmd_valid  out  head entry offered to the sequencer
//   cmd_ready  in   sequencer accepts the head entry
//   cmd_addr   out  24-bit bus address of the head entry
//   cmd_data   out  write data of the head entry
//   cmd_rw     out  1 = read, 0 = write
//   cmd_uds_n  out  upper byte strobe, active-low
//   cmd_lds_n  out  lower byte strobe, active-low
//   cmd_done   in   one-cycle pulse, the in-flight bus cycle has finished
//   busy       out  a transaction is staged, queued or in flight
//   full       out  FIFO count equals DEPTH
//   level      out  FIFO count
//   ovf        out  sticky, a commit was dropped because the FIFO was full

module pi_cmd_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     PI_CLK,
   input  logic                     PI_RST,
   input  logic                     wr_stb,
   input  logic [1:0]               wr_reg,
   input  logic [15:0]              wr_data,
   input  logic                     clr_ovf,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [23:0]              cmd_addr,
   output logic [15:0]              cmd_data,
   output logic                     cmd_rw,
   output logic                     cmd_uds_n,
   output logic                     cmd_lds_n,
   input  logic                     cmd_done,
   output logic                     busy,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [AW-1:0] PtrOne  = AW'(1);
   localparam logic [CW-1:0] CntOne  = CW'(1);
   localparam logic [CW-1:0] CntFull = CW'(DEPTH);

   typedef enum logic [1:0] {
      RegData   = 2'd0,
      RegAddrLo = 2'd1,
      RegAddrHi = 2'd2,
      RegStatus = 2'd3
   } reg_sel_e;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
      logic        rw;
      logic        uds_n;
      logic        lds_n;
   } entry_t;

   // Idle entry: what the outputs show out of reset (read, no lanes strobed).
   localparam entry_t EntryIdle = '{
      addr:  24'h000000,
      data:  16'h0000,
      rw:    1'b1,
      uds_n: 1'b1,
      lds_n: 1'b1
   };

   // ----------------------------------------------------------------------
   // State
   // ----------------------------------------------------------------------
   logic [15:0]   stg_data_q, stg_data_d;
   logic [15:0]   stg_addr_q, stg_addr_d;
   logic          stg_pend_q, stg_pend_d;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          infl_q, infl_d;
   logic          ovf_q, ovf_d;

   // ----------------------------------------------------------------------
   // Decode and handshake
   // ----------------------------------------------------------------------
   logic   commit;
   logic   pop;
   logic   push_ok;
   logic   drop;
   logic   is_full;
   entry_t new_entry;
   entry_t head;

   assign is_full   = (count_q == CntFull);
   assign commit    = wr_stb && (wr_reg == RegAddrHi);
   assign cmd_valid = (count_q != '0) && !infl_q;
   assign pop       = cmd_valid && cmd_ready;
   // A pop in the same cycle frees the slot the full FIFO needs.
   assign push_ok   = commit && (!is_full || pop);
   assign drop      = commit && is_full && !pop;

   always_comb begin
      new_entry       = EntryIdle;
      new_entry.addr  = {wr_data[7:0], stg_addr_q};
      new_entry.data  = stg_data_q;
      new_entry.rw    = wr_data[9];
      if (wr_data[8]) begin
         // Byte cycle: even address uses the upper lane on the 68k.
         new_entry.uds_n = stg_addr_q[0];
         new_entry.lds_n = ~stg_addr_q[0];
      end else begin
         new_entry.uds_n = 1'b0;
         new_entry.lds_n = 1'b0;
      end
   end

   // ----------------------------------------------------------------------
   // Staging registers
   // ----------------------------------------------------------------------
   always_comb begin
      stg_data_d = stg_data_q;
      stg_addr_d = stg_addr_q;
      stg_pend_d = stg_pend_q;
      if (wr_stb) begin
         unique case (wr_reg)
            RegData: begin
               stg_data_d = wr_data;
            end
            RegAddrLo: begin
               stg_addr_d = wr_data;
               stg_pend_d = 1'b1;
            end
            RegAddrHi: begin
`ifdef PI_CMD_FIFO_AUTOINC_EN
               // Dropped commits leave the address in place so the Pi can retry.
               if (push_ok) begin
                  stg_addr_d = stg_addr_q + (wr_data[8] ? 16'd1 : 16'd2);
               end
`else
               stg_pend_d = 1'b0;
`endif
            end
            RegStatus: begin
               // Status writes are handled elsewhere.
            end
            default: begin
            end
         endcase
      end
   end

   // ----------------------------------------------------------------------
   // FIFO pointers, count, in-flight and overflow
   // ----------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      infl_d   = infl_q;
      ovf_d    = ovf_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end

      if (push_ok && !pop) begin
         count_d = count_q + CntOne;
      end else if (!push_ok && pop) begin
         count_d = count_q - CntOne;
      end

      // pop needs !infl_q, so a pop and a meaningful done never coincide.
      if (pop) begin
         infl_d = 1'b1;
      end else if (cmd_done) begin
         infl_d = 1'b0;
      end

      // Set has priority over clear.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge PI_CLK) begin
      if (PI_RST) begin
         stg_data_q <= '0;
         stg_addr_q <= '0;
         stg_pend_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         infl_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         stg_data_q <= stg_data_d;
         stg_addr_q <= stg_addr_d;
         stg_pend_q <= stg_pend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         infl_q     <= infl_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage is reset so the head outputs show the idle entry out of reset.
   always_ff @(posedge PI_CLK) begin
      if (PI_RST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= EntryIdle;
         end
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= new_entry;
      end
   end

   // ----------------------------------------------------------------------
   // Outputs
   // ----------------------------------------------------------------------
   assign head      = mem_q[rd_ptr_q];
   assign cmd_addr  = head.addr;
   assign cmd_data  = head.data;
   assign cmd_rw    = head.rw;
   assign cmd_uds_n = head.uds_n;
   assign cmd_lds_n = head.lds_n;

   assign busy  = stg_pend_q || (count_q != '0) || infl_q;
   assign full  = is_full;
   assign level = count_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_pi_cmd_fifo.sv
// Directed self-checking bench for pi_cmd_fifo (DEPTH = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.

module tb_pi_cmd_fifo;

   localparam int DEPTH = 4;
`ifdef PI_CMD_FIFO_AUTOINC_EN
   localparam logic AutoInc = 1'b1;
`else
   localparam logic AutoInc = 1'b0;
`endif

   logic        PI_CLK;
   logic        PI_RST;
   logic        wr_stb;
   logic [1:0]  wr_reg;
   logic [15:0] wr_data;
   logic        clr_ovf;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_rw;
   logic        cmd_uds_n;
   logic        cmd_lds_n;
   logic        cmd_done;
   logic        busy;
   logic        full;
   logic [$clog2(DEPTH):0] level;
   logic        ovf;

   int checks;
   int failures;

   pi_cmd_fifo #(.DEPTH(DEPTH)) dut (
      .PI_CLK    (PI_CLK),
      .PI_RST    (PI_RST),
      .wr_stb    (wr_stb),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .clr_ovf   (clr_ovf),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .cmd_rw    (cmd_rw),
      .cmd_uds_n (cmd_uds_n),
      .cmd_lds_n (cmd_lds_n),
      .cmd_done  (cmd_done),
      .busy      (busy),
      .full      (full),
      .level     (level),
      .ovf       (ovf)
   );

   initial PI_CLK = 1'b0;
   always #5 PI_CLK = ~PI_CLK;

   task automatic tick();
      @(posedge PI_CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] r, input logic [15:0] d);
      wr_stb  = 1'b1;
      wr_reg  = r;
      wr_data = d;
      tick();
      wr_stb  = 1'b0;
   endtask

   task automatic pulse_done();
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
   endtask

   task automatic pop_one();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   task automatic do_reset();
      PI_RST = 1'b1;
      tick();
      tick();
      PI_RST = 1'b0;
   endtask

   // Reset values, checked once reset is released with no activity.
   task automatic test_reset();
      do_reset();
      tick();
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", cmd_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", full); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
      checks++; if (cmd_addr !== 24'h000000) begin failures++; $display("FAIL rst_addr got=%h exp=000000", cmd_addr); end
      checks++; if (cmd_data !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", cmd_data); end
      checks++; if ({cmd_rw, cmd_uds_n, cmd_lds_n} !== 3'b111) begin failures++; $display("FAIL rst_ctl got=%b exp=111", {cmd_rw, cmd_uds_n, cmd_lds_n}); end
   endtask

   task automatic test_single_word();
      do_reset();
      wr(2'd0, 16'hBEEF);
      wr(2'd1, 16'h1234);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy_stage got=%0b exp=1", busy); end
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL sw_valid_pre got=%0b exp=0", cmd_valid); end
      wr(2'd2, 16'h0012);
      checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL sw_valid got=%0b exp=1", cmd_valid); end
      checks++; if (cmd_addr !== 24'h121234) begin failures++; $display("FAIL sw_addr got=%h exp=121234", cmd_addr); end
      checks++; if (cmd_data !== 16'hBEEF) begin failures++; $display("FAIL sw_data got=%h exp=beef", cmd_data); end
      checks++; if ({cmd_rw, cmd_uds_n, cmd_lds_n} !== 3'b000) begin failures++; $display("FAIL sw_ctl got=%b exp=000", {cmd_rw, cmd_uds_n, cmd_lds_n}); end
      checks++; if (level !== 3'd1) begin failures++; $display("FAIL sw_level got=%0d exp=1", level); end
      // Held without ready: outputs stay put.
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 24'h121234) begin failures++; $display("FAIL sw_hold got=%0b/%h exp=1/121234", cmd_valid, cmd_addr); end
      pop_one();
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL sw_valid_infl got=%0b exp=0", cmd_valid); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL sw_level_pop got=%0d exp=0", level); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy_infl got=%0b exp=1", busy); end
      pulse_done();
      checks++; if (busy !== AutoInc) begin failures++; $display("FAIL sw_busy_done got=%0b exp=%0b", busy, AutoInc); end
   endtask

   task automatic test_byte_reads();
      do_reset();
      wr(2'd1, 16'h0001);
      wr(2'd2, 16'h0300);
      checks++; if (cmd_addr !== 24'h000001) begin failures++; $display("FAIL br_odd_addr got=%h exp=000001", cmd_addr); end
      checks++; if ({cmd_rw, cmd_uds_n, cmd_lds_n} !== 3'b110) begin failures++; $display("FAIL br_odd_ctl got=%b exp=110", {cmd_rw, cmd_uds_n, cmd_lds_n}); end
      pop_one();
      pulse_done();
      wr(2'd1, 16'h0000);
      wr(2'd2, 16'h0300);
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 24'h000000) begin failures++; $display("FAIL br_even_addr got=%0b/%h exp=1/000000", cmd_valid, cmd_addr); end
      checks++; if ({cmd_rw, cmd_uds_n, cmd_lds_n} !== 3'b101) begin failures++; $display("FAIL br_even_ctl got=%b exp=101", {cmd_rw, cmd_uds_n, cmd_lds_n}); end
      pop_one();
      pulse_done();
   endtask

   task automatic test_overflow();
      logic [23:0] exp_a [4];
      logic [15:0] exp_d [4];
      do_reset();
      cmd_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wr(2'd0, 16'(16'hA000 + i));
         wr(2'd1, 16'(16'h0100 + i));
         wr(2'd2, 16'h0020);
      end
      checks++; if (full !== 1'b1 || level !== 3'd4) begin failures++; $display("FAIL ov_full got=%0b/%0d exp=1/4", full, level); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ov_ovf_pre got=%0b exp=0", ovf); end
      // Dropped commit with a simultaneous clear: set wins.
      wr(2'd0, 16'hA004);
      wr(2'd1, 16'h0104);
      clr_ovf = 1'b1;
      wr(2'd2, 16'h0020);
      clr_ovf = 1'b0;
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ov_ovf_set got=%0b exp=1", ovf); end
      checks++; if (full !== 1'b1 || level !== 3'd4) begin failures++; $display("FAIL ov_full_drop got=%0b/%0d exp=1/4", full, level); end
      checks++; if (cmd_addr !== 24'h200100 || cmd_data !== 16'hA000) begin failures++; $display("FAIL ov_head got=%h/%h exp=200100/a000", cmd_addr, cmd_data); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ov_ovf_clr got=%0b exp=0", ovf); end
      // Commit while full together with a pop: accepted, count unchanged.
      wr(2'd1, 16'h0180);
      cmd_ready = 1'b1;
      wr(2'd2, 16'h0020);
      cmd_ready = 1'b0;
      checks++; if (full !== 1'b1 || level !== 3'd4) begin failures++; $display("FAIL ov_pushpop_lvl got=%0b/%0d exp=1/4", full, level); end
      checks++; if (ovf !== 1'b0 || cmd_valid !== 1'b0) begin failures++; $display("FAIL ov_pushpop_flags got=%0b/%0b exp=0/0", ovf, cmd_valid); end
      exp_a[0] = 24'h200101; exp_d[0] = 16'hA001;
      exp_a[1] = 24'h200102; exp_d[1] = 16'hA002;
      exp_a[2] = 24'h200103; exp_d[2] = 16'hA003;
      exp_a[3] = 24'h200180; exp_d[3] = 16'hA004;
      for (int j = 0; j < 4; j++) begin
         pulse_done();
         checks++; if (cmd_valid !== 1'b1 || cmd_addr !== exp_a[j] || cmd_data !== exp_d[j]) begin
            failures++;
            $display("FAIL ov_drain%0d got=%0b/%h/%h exp=1/%h/%h", j, cmd_valid, cmd_addr, cmd_data, exp_a[j], exp_d[j]);
         end
         pop_one();
      end
      pulse_done();
      checks++; if (level !== 3'd0 || full !== 1'b0) begin failures++; $display("FAIL ov_empty got=%0d/%0b exp=0/0", level, full); end
   endtask

   task automatic test_one_in_flight();
      logic [23:0] exp_a [3];
      do_reset();
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, 16'(16'h4000 + i));
         wr(2'd2, 16'h0033);
      end
      exp_a[0] = 24'h334000;
      exp_a[1] = 24'h334001;
      exp_a[2] = 24'h334002;
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (cmd_valid !== 1'b1 || cmd_addr !== exp_a[i]) begin
            failures++;
            $display("FAIL fl_offer%0d got=%0b/%h exp=1/%h", i, cmd_valid, cmd_addr, exp_a[i]);
         end
         tick();
         tick();
         tick();
         checks++; if (cmd_valid !== 1'b0 || level !== 3'(2 - i)) begin
            failures++;
            $display("FAIL fl_hold%0d got=%0b/%0d exp=0/%0d", i, cmd_valid, level, 2 - i);
         end
         pulse_done();
      end
      cmd_ready = 1'b0;
      checks++; if (busy !== AutoInc || cmd_valid !== 1'b0) begin failures++; $display("FAIL fl_end got=%0b/%0b exp=%0b/0", busy, cmd_valid, AutoInc); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, 16'(16'h7770 + i));
         wr(2'd2, 16'h0101);
      end
      pop_one();
      checks++; if (level !== 3'd2 || cmd_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0d/%0b/%0b exp=2/0/1", level, cmd_valid, busy); end
      PI_RST = 1'b1;
      tick();
      PI_RST = 1'b0;
      checks++; if ({cmd_valid, busy, full, ovf} !== 4'b0000 || level !== 3'd0) begin failures++; $display("FAIL rm_flags got=%b/%0d exp=0000/0", {cmd_valid, busy, full, ovf}, level); end
      checks++; if (cmd_addr !== 24'h0 || cmd_data !== 16'h0 || {cmd_rw, cmd_uds_n, cmd_lds_n} !== 3'b111) begin
         failures++;
         $display("FAIL rm_head got=%h/%h/%b exp=000000/0000/111", cmd_addr, cmd_data, {cmd_rw, cmd_uds_n, cmd_lds_n});
      end
      pulse_done();
      checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL rm_done got=%0b/%0b/%0d exp=0/0/0", busy, cmd_valid, level); end
   endtask

`ifdef PI_CMD_FIFO_AUTOINC_EN
   task automatic test_autoinc();
      do_reset();
      wr(2'd0, 16'h1111);
      wr(2'd1, 16'hFFFE);
      wr(2'd2, 16'h0005);
      wr(2'd2, 16'h0005);
      checks++; if (level !== 3'd2) begin failures++; $display("FAIL ai_level got=%0d exp=2", level); end
      checks++; if (cmd_addr !== 24'h05FFFE) begin failures++; $display("FAIL ai_addr0 got=%h exp=05fffe", cmd_addr); end
      pop_one();
      pulse_done();
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 24'h050000) begin failures++; $display("FAIL ai_addr1 got=%0b/%h exp=1/050000", cmd_valid, cmd_addr); end
      pop_one();
      pulse_done();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ai_pend got=%0b exp=1", busy); end
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      PI_RST    = 1'b1;
      wr_stb    = 1'b0;
      wr_reg    = 2'd0;
      wr_data   = 16'h0000;
      clr_ovf   = 1'b0;
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      test_reset();
      test_single_word();
      test_byte_reads();
      test_overflow();
      test_one_in_flight();
      test_reset_mid();
`ifdef PI_CMD_FIFO_AUTOINC_EN
      test_autoinc();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
